// File: rtl/curve_lut_pipeline.sv
// Two-stage signed-clamp LUT pipeline with ready/valid handshake and a cfg write port.
// Define CURVE_LUT_INIT_FILL_EN to add the post-reset FILL state that loads LUT[k] = k >> INIT_SHIFT.
module curve_lut_pipeline #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 256,
  parameter int INIT_SHIFT = 2,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic             busy
);
  localparam logic [WIDTH:0] MAX_IDX = (WIDTH+1)'(DEPTH - 1);

  logic [WIDTH-1:0] lut [DEPTH];
  logic             run;
  logic             adv;
  logic [AW-1:0]    clamp_addr;
  logic [AW-1:0]    a_addr;
  logic             a_valid;
  logic             lut_we;
  logic [AW-1:0]    lut_waddr;
  logic [WIDTH-1:0] lut_wdata;
  logic             fill_we;
  logic [AW-1:0]    fill_addr;
  logic [WIDTH-1:0] fill_data;

`ifdef CURVE_LUT_INIT_FILL_EN
  // state | meaning
  // FILL  | loading LUT[k] = k >> INIT_SHIFT, one entry per cycle
  // RUN   | streaming samples, cfg writes accepted
  typedef enum logic {FILL, RUN} state_t;

  state_t        state;
  logic [AW-1:0] fill_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      busy     <= 1'b1;
    end else if (state == FILL) begin
      if (fill_cnt == AW'(DEPTH - 1)) begin
        state <= RUN;
        busy  <= 1'b0;
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  assign run       = (state == RUN);
  assign fill_we   = (state == FILL) & ~rst;
  assign fill_addr = fill_cnt;
  assign fill_data = WIDTH'(fill_cnt >> INIT_SHIFT);
`else
  assign run       = 1'b1;
  assign busy      = 1'b0;
  assign fill_we   = 1'b0;
  assign fill_addr = '0;
  assign fill_data = '0;
`endif

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & run & ~rst;

  always_comb begin
    if (in_data[WIDTH-1]) begin
      clamp_addr = '0;
    end else if ({1'b0, in_data} > MAX_IDX) begin
      clamp_addr = AW'(DEPTH - 1);
    end else begin
      clamp_addr = in_data[AW-1:0];
    end
  end

  // Fill and cfg never write in the same cycle, so a simple priority mux suffices.
  assign lut_we    = fill_we | (cfg_we & run & ~rst);
  assign lut_waddr = fill_we ? fill_addr : cfg_addr;
  assign lut_wdata = fill_we ? fill_data : cfg_wdata;

  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  // Both stages advance together; the stage-B read sees pre-write data on a same-edge cfg write.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      a_valid   <= in_valid & in_ready;
      a_addr    <= clamp_addr;
      out_valid <= a_valid;
      out_data  <= lut[a_addr];
    end
  end

endmodule

// File: tb/tb_curve_lut_pipeline.sv
// Self-checking bench for curve_lut_pipeline: reference LUT array plus expected-output queue.
module tb_curve_lut_pipeline;
  localparam int DEPTH = 256;
  localparam int SHIFT = 2;
`ifdef CURVE_LUT_INIT_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] model_lut [DEPTH];

  curve_lut_pipeline #(.WIDTH(16), .DEPTH(DEPTH), .INIT_SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp_idx(input logic [15:0] d);
    int x;
    x = int'($signed(d));
    if (x < 0) return 0;
    if (x > DEPTH - 1) return DEPTH - 1;
    return x;
  endfunction

  // Inputs change on the falling edge; outputs are read 1 time unit later.
  task automatic drive(input logic iv, input logic [15:0] d, input logic ordy,
                       input logic we, input logic [7:0] a, input logic [15:0] wd);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = wd;
    #1;
  endtask

  task automatic test_reset();
    logic exp_busy;
    exp_busy = FILL_EN;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", busy, exp_busy); end
  endtask

  task automatic test_fill();
    int   cnt;
    int   exp_cnt;
    int   busy_bad;
    logic first_rdy;
    logic exp_first;
    exp_cnt   = FILL_EN ? DEPTH : 0;
    exp_first = !FILL_EN;
    cnt       = 0;
    @(negedge clk);
    // Writes to entry 0 while filling must be ignored.
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_we = FILL_EN; cfg_addr = 8'd0; cfg_wdata = 16'hffff;
    #1;
    first_rdy = in_ready;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk); #1;
    end
    cfg_we = 1'b0;
    n_tests++; if (cnt != exp_cnt) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d expected %0d", cnt, exp_cnt); end
    n_tests++; if (first_rdy !== exp_first) begin n_fail++; $display("FAIL first_in_ready: got %b expected %b", first_rdy, exp_first); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_busy: got %b expected 0", busy); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL run_in_ready: got %b expected 1", in_ready); end
`ifdef CURVE_LUT_INIT_FILL_EN
    for (int k = 0; k < DEPTH; k++) model_lut[k] = 16'(k >> SHIFT);
`else
    busy_bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      model_lut[k] = 16'($urandom);
      drive(1'b0, 16'h0, 1'b1, 1'b1, 8'(k), model_lut[k]);
      if (busy !== 1'b0) busy_bad++;
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0, 8'd0, 16'h0);
    n_tests++; if (busy_bad != 0) begin n_fail++; $display("FAIL nofill_busy: got %0d busy cycles expected 0", busy_bad); end
`endif
  endtask

  task automatic test_clamp();
    int          vals [6];
    logic [15:0] d;
    logic [15:0] e;
    vals = '{-5, 0, 1023, 1020, 600, 255};
    for (int i = 0; i < 8; i++) begin
      d = (i < 6) ? 16'(vals[i]) : 16'h0;
      drive(i < 6, d, 1'b1, 1'b0, 8'd0, 16'h0);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clamp_in_ready[%0d]: got %b expected 1", i, in_ready); end
      if (i >= 2) begin
        e = model_lut[clamp_idx(16'(vals[i-2]))];
        n_tests++; if (out_valid !== 1'b1 || out_data !== e) begin
          n_fail++; $display("FAIL clamp_out[%0d]: got v=%b d=%h expected v=1 d=%h", i - 2, out_valid, out_data, e);
        end
      end else begin
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_latency[%0d]: got v=%b expected 0", i, out_valid); end
      end
    end
  endtask

  task automatic test_stream(input string name, input int n, input bit rnd);
    logic [15:0] exp_q [$];
    logic [15:0] d;
    logic [15:0] e;
    logic [15:0] held;
    bit          iv;
    bit          ordy;
    bit          stalled;
    int          sent;
    int          rcvd;
    int          cyc;
    sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = '0;
    while ((sent < n || rcvd < n) && cyc < 2000) begin
      iv   = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      ordy = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc < 7);
      d    = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 300));
      drive(iv, d, ordy, 1'b0, 8'd0, 16'h0);
      if (stalled) begin
        n_tests++; if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++; $display("FAIL %s_stable: got v=%b d=%h expected v=1 d=%h", name, out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1 && !ordy) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_stall_ready: got %b expected 0", name, in_ready); end
      end
      if (ordy) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b expected 1", name, in_ready); end
      end
      if (iv && in_ready === 1'b1) begin
        exp_q.push_back(model_lut[clamp_idx(d)]);
        sent++;
      end
      if (out_valid === 1'b1 && ordy) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s_extra: got d=%h expected no output", name, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin n_fail++; $display("FAIL %s_data[%0d]: got %h expected %h", name, rcvd, out_data, e); end
        end
        rcvd++;
      end
      stalled = (out_valid === 1'b1) && !ordy;
      held    = out_data;
      cyc++;
    end
    n_tests++; if (sent != n || rcvd != n) begin
      n_fail++; $display("FAIL %s_count: got sent=%0d rcvd=%0d expected %0d each", name, sent, rcvd, n);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0, 8'd0, 16'h0);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drain[%0d]: got v=%b expected 0", name, i, out_valid); end
    end
  endtask

  task automatic test_program();
    logic [15:0] old7;
    old7 = model_lut[7];
    drive(1'b1, 16'd7, 1'b1, 1'b0, 8'd0, 16'h0);
    // Write lands on the same edge at which stage B reads entry 7 for the sample above.
    drive(1'b0, 16'h0, 1'b1, 1'b1, 8'd7, 16'h1234);
    drive(1'b1, 16'd7, 1'b1, 1'b0, 8'd0, 16'h0);
    n_tests++; if (out_valid !== 1'b1 || out_data !== old7) begin
      n_fail++; $display("FAIL prog_old: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, old7);
    end
    model_lut[7] = 16'h1234;
    drive(1'b0, 16'h0, 1'b1, 1'b0, 8'd0, 16'h0);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 8'd0, 16'h0);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      n_fail++; $display("FAIL prog_new: got v=%b d=%h expected v=1 d=1234", out_valid, out_data);
    end
    drive(1'b0, 16'h0, 1'b1, 1'b1, 8'd3, 16'd9);
    model_lut[3] = 16'd9;
    drive(1'b1, 16'd3, 1'b1, 1'b0, 8'd0, 16'h0);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 8'd0, 16'h0);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 8'd0, 16'h0);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 16'd9) begin
      n_fail++; $display("FAIL prog_lut3: got v=%b d=%h expected v=1 d=0009", out_valid, out_data);
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0, 8'd0, 16'h0);
  endtask

  task automatic test_midrun_reset();
    int   cnt;
    int   nbad;
    int   exp_cnt;
    logic exp_busy;
    exp_cnt  = FILL_EN ? DEPTH : 0;
    exp_busy = FILL_EN;
    drive(1'b1, 16'($urandom_range(0, 255)), 1'b1, 1'b0, 8'd0, 16'h0);
    drive(1'b1, 16'($urandom_range(0, 255)), 1'b1, 1'b0, 8'd0, 16'h0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got v=%b expected 1", out_valid); end
    @(negedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL mid_busy: got %b expected %b", busy, exp_busy); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    cnt = 0; nbad = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      if (out_valid !== 1'b0) nbad++;
      @(negedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) nbad++;
      drive(1'b0, 16'h0, 1'b1, 1'b0, 8'd0, 16'h0);
    end
    n_tests++; if (cnt != exp_cnt) begin n_fail++; $display("FAIL mid_refill_cycles: got %0d expected %0d", cnt, exp_cnt); end
    n_tests++; if (nbad != 0) begin n_fail++; $display("FAIL mid_stale_out: got %0d valid cycles expected 0", nbad); end
`ifdef CURVE_LUT_INIT_FILL_EN
    for (int k = 0; k < DEPTH; k++) model_lut[k] = 16'(k >> SHIFT);
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_clamp();
    test_stream("backpressure", 10, 1'b0);
    test_stream("random", 200, 1'b1);
    test_program();
    test_midrun_reset();
    test_stream("post_reset", 30, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
